// File: rtl/uart_bridge_pkg.sv
// Shared types and defaults for the UART-to-APB bridge front end.
// Holds the decoder state encoding, default command bytes and default frame geometry.
// Pure declarations: no logic, no latency, no flow control.
package uart_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ADDR  = 2'd1,
        DATA  = 2'd2,
        ISSUE = 2'd3
    } dec_state_t;

    localparam logic [7:0] CMD_WR_DEFAULT = 8'h57;  // 'W'
    localparam logic [7:0] CMD_RD_DEFAULT = 8'h52;  // 'R'

    localparam int DEF_WIDTH    = 32;
    localparam int DEF_ADDRBITS = 16;
    localparam int ADDR_BYTES   = DEF_ADDRBITS / 8;
    localparam int DATA_BYTES   = DEF_WIDTH / 8;

    // Larger of two byte counts, used to size the shared frame byte counter.
    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/frame_gap_timer.sv
// Inter-byte gap counter: counts idle cycles and flags the terminal count.
// Latency: expire is combinational in the cycle the count sits at CYCLES-1 with tick high.
// Backpressure: none; clear has priority over tick and restarts the count.
import uart_bridge_pkg::*;

module frame_gap_timer #(
    parameter int CYCLES = 100000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic tick,
    output logic expire
);

    localparam int CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;

    logic [CW-1:0] count;

    assign expire = tick && !clear && (count == CW'(CYCLES - 1));

    // Count idle cycles; any clear (byte popped or frame not in progress) restarts from zero.
    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (tick) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/uart_cmd_decoder.sv
// Assembles command/address/data frames from the RX FIFO into APB requests.
// Latency: last frame byte popped in cycle N -> dec_en high in cycle N+1 (wait_fifo low).
// Backpressure: stops popping while a request is held; holds dec_en low while wait_fifo is high.
// Optional: FRAME_TIMEOUT_EN drops a partial frame after TIMEOUT_CYCLES idle cycles mid-frame.
import uart_bridge_pkg::*;

module uart_cmd_decoder #(
    parameter int         WIDTH          = DEF_WIDTH,
    parameter int         ADDRBITS       = DEF_ADDRBITS,
    parameter logic [7:0] CMD_WR         = CMD_WR_DEFAULT,
    parameter logic [7:0] CMD_RD         = CMD_RD_DEFAULT,
    parameter int         TIMEOUT_CYCLES = 100000
) (
    input  logic                apb_clk,
    input  logic                reset,
    input  logic [7:0]          rx_data,
    input  logic                rx_empty,
    output logic                rx_ren,
    input  logic                wait_fifo,
    input  logic                dec_ack,
    output logic                dec_en,
    output logic                wr,
    output logic [ADDRBITS-1:0] daddr,
    output logic [WIDTH-1:0]    wdatadec,
    output logic                frame_err
);

    localparam int N_ADDR = ADDRBITS / 8;
    localparam int N_DATA = WIDTH / 8;
    localparam int CNT_W  = $clog2(max2(N_ADDR, N_DATA) + 1);

    dec_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic             tmo;

    // Pop whenever a byte is available and the decoder is still collecting a frame.
    assign rx_ren = reset && !rx_empty && (state != ISSUE);

`ifdef FRAME_TIMEOUT_EN
    logic gap_clear;

    // Gap only counts while a frame is partially received; a pop restarts it.
    assign gap_clear = rx_ren || !((state == ADDR) || (state == DATA));

    frame_gap_timer #(
        .CYCLES (TIMEOUT_CYCLES)
    ) u_gap_timer (
        .clk    (apb_clk),
        .reset  (reset),
        .clear  (gap_clear),
        .tick   (rx_empty),
        .expire (tmo)
    );
`else
    assign tmo = 1'b0;
`endif

    // Frame decoder FSM with registered request outputs.
    always_ff @(posedge apb_clk) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            dec_en    <= 1'b0;
            wr        <= 1'b0;
            daddr     <= '0;
            wdatadec  <= '0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (rx_ren) begin
                        cnt <= '0;
                        if (rx_data == CMD_WR) begin
                            wr    <= 1'b1;
                            state <= ADDR;
                        end else if (rx_data == CMD_RD) begin
                            wr    <= 1'b0;
                            state <= ADDR;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end
                end
                ADDR: begin
                    if (rx_ren) begin
                        daddr <= {daddr[ADDRBITS-9:0], rx_data};
                        if (cnt == CNT_W'(N_ADDR - 1)) begin
                            cnt <= '0;
                            if (wr) begin
                                state <= DATA;
                            end else begin
                                wdatadec <= '0;
                                dec_en   <= !wait_fifo;
                                state    <= ISSUE;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end else if (tmo) begin
                        cnt       <= '0;
                        frame_err <= 1'b1;
                        state     <= IDLE;
                    end
                end
                DATA: begin
                    if (rx_ren) begin
                        wdatadec <= {wdatadec[WIDTH-9:0], rx_data};
                        if (cnt == CNT_W'(N_DATA - 1)) begin
                            cnt    <= '0;
                            dec_en <= !wait_fifo;
                            state  <= ISSUE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end else if (tmo) begin
                        cnt       <= '0;
                        frame_err <= 1'b1;
                        state     <= IDLE;
                    end
                end
                ISSUE: begin
                    if (dec_en && dec_ack) begin
                        dec_en <= 1'b0;
                        cnt    <= '0;
                        state  <= IDLE;
                    end else begin
                        dec_en <= !wait_fifo;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Self-checking bench for uart_cmd_decoder: RX FIFO byte queue plus request scoreboard.
// Inputs change 1 ns after the rising edge; outputs are sampled 2 ns after it.
// Define FRAME_TIMEOUT_EN to run the gap-timeout scenario with an 8-cycle limit.
module tb_uart_cmd_decoder;

`ifdef FRAME_TIMEOUT_EN
    localparam int TB_TIMEOUT = 8;
`else
    localparam int TB_TIMEOUT = 100000;
`endif

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [31:0] data;
    } req_t;

    logic        apb_clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_empty = 1'b1;
    logic        rx_ren;
    logic        wait_fifo = 1'b0;
    logic        dec_ack = 1'b0;
    logic        dec_en;
    logic        wr;
    logic [15:0] daddr;
    logic [31:0] wdatadec;
    logic        frame_err;

    logic [7:0] rxq[$];
    req_t       exq[$];
    req_t       r;
    logic       ren_neg = 1'b0;
    int         n_cmp = 0;
    int         n_bad = 0;
    int         n_ren;

    uart_cmd_decoder #(
        .WIDTH          (32),
        .ADDRBITS       (16),
        .CMD_WR         (8'h57),
        .CMD_RD         (8'h52),
        .TIMEOUT_CYCLES (TB_TIMEOUT)
    ) dut (
        .apb_clk   (apb_clk),
        .reset     (reset),
        .rx_data   (rx_data),
        .rx_empty  (rx_empty),
        .rx_ren    (rx_ren),
        .wait_fifo (wait_fifo),
        .dec_ack   (dec_ack),
        .dec_en    (dec_en),
        .wr        (wr),
        .daddr     (daddr),
        .wdatadec  (wdatadec),
        .frame_err (frame_err)
    );

    always #5 apb_clk = ~apb_clk;

    // Record the pop strobe mid-cycle, where it is settled before the next edge.
    always @(negedge apb_clk) ren_neg = rx_ren;

    task automatic refresh();
        rx_empty = (rxq.size() == 0);
        rx_data  = rx_empty ? 8'h00 : rxq[0];
    endtask

    // One clock: model the FIFO pop, present the next head byte, settle.
    task automatic cyc();
        @(posedge apb_clk);
        #1;
        if (ren_neg && rxq.size() > 0) void'(rxq.pop_front());
        refresh();
        #1;
    endtask

    task automatic push_bytes(input logic [7:0] b[$]);
        foreach (b[i]) rxq.push_back(b[i]);
        refresh();
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        push_bytes('{8'h57});
        cyc(); cyc();
        n_cmp++; if (rx_ren !== 1'b0) begin n_bad++; $display("FAIL reset_rx_ren: got %b want 0", rx_ren); end
        n_cmp++; if ({dec_en, wr, frame_err} !== 3'b000) begin n_bad++; $display("FAIL reset_flags: got %b want 000", {dec_en, wr, frame_err}); end
        n_cmp++; if ({daddr, wdatadec} !== 48'h0) begin n_bad++; $display("FAIL reset_buses: got %h want 0", {daddr, wdatadec}); end
        rxq.delete();
        refresh();
        reset = 1'b1;
        cyc();
    endtask

    task automatic test_write();
        push_bytes('{8'h57, 8'h12, 8'h34, 8'hDE, 8'hAD, 8'hBE, 8'hEF});
        exq.push_back('{1'b1, 16'h1234, 32'hDEADBEEF});
        n_ren = 0;
        for (int i = 0; i < 7; i++) begin
            if (rx_ren === 1'b1 && dec_en === 1'b0) n_ren++;
            cyc();
        end
        n_cmp++; if (n_ren !== 7) begin n_bad++; $display("FAIL wr_pop_run: got %0d want 7", n_ren); end
        n_cmp++; if (dec_en !== 1'b1 || rx_ren !== 1'b0) begin n_bad++; $display("FAIL wr_latency: dec_en=%b rx_ren=%b want 1 0", dec_en, rx_ren); end
        r = exq.pop_front();
        n_cmp++; if ({wr, daddr, wdatadec} !== {r.wr, r.addr, r.data}) begin n_bad++; $display("FAIL wr_fields: got %b %h %h want %b %h %h", wr, daddr, wdatadec, r.wr, r.addr, r.data); end
        cyc(); cyc(); cyc();
        n_cmp++; if ({dec_en, wr, daddr, wdatadec} !== {1'b1, r.wr, r.addr, r.data}) begin n_bad++; $display("FAIL wr_hold: got %b %b %h %h", dec_en, wr, daddr, wdatadec); end
        dec_ack = 1'b1;
        cyc();
        dec_ack = 1'b0;
        n_cmp++; if (dec_en !== 1'b0) begin n_bad++; $display("FAIL wr_ack_drop: got %b want 0", dec_en); end
    endtask

    task automatic test_read_wait();
        wait_fifo = 1'b1;
        push_bytes('{8'h52, 8'h00, 8'h08});
        exq.push_back('{1'b0, 16'h0008, 32'h0});
        cyc(); cyc(); cyc();
        n_ren = 0;
        for (int i = 0; i < 5; i++) begin
            if (dec_en !== 1'b0) n_ren++;
            dec_ack = 1'b1;
            cyc();
        end
        dec_ack = 1'b0;
        n_cmp++; if (n_ren !== 0) begin n_bad++; $display("FAIL rd_wait_hold: dec_en high %0d cycles want 0", n_ren); end
        wait_fifo = 1'b0;
        n_cmp++; if (dec_en !== 1'b0) begin n_bad++; $display("FAIL rd_wait_reg: got %b want 0", dec_en); end
        cyc();
        n_cmp++; if (dec_en !== 1'b1) begin n_bad++; $display("FAIL rd_rise: got %b want 1", dec_en); end
        r = exq.pop_front();
        n_cmp++; if ({wr, daddr, wdatadec} !== {r.wr, r.addr, r.data}) begin n_bad++; $display("FAIL rd_fields: got %b %h %h want %b %h %h", wr, daddr, wdatadec, r.wr, r.addr, r.data); end
        dec_ack = 1'b1; cyc(); dec_ack = 1'b0;
    endtask

    task automatic test_bad_cmd();
        push_bytes('{8'h41, 8'h52, 8'h00, 8'h04});
        exq.push_back('{1'b0, 16'h0004, 32'h0});
        cyc();
        n_cmp++; if (frame_err !== 1'b1) begin n_bad++; $display("FAIL bad_err_pulse: got %b want 1", frame_err); end
        cyc();
        n_cmp++; if (frame_err !== 1'b0) begin n_bad++; $display("FAIL bad_err_len: got %b want 0", frame_err); end
        cyc(); cyc();
        r = exq.pop_front();
        n_cmp++; if ({dec_en, wr, daddr, wdatadec} !== {1'b1, r.wr, r.addr, r.data}) begin n_bad++; $display("FAIL bad_next_rd: got %b %b %h %h want 1 %b %h %h", dec_en, wr, daddr, wdatadec, r.wr, r.addr, r.data); end
        dec_ack = 1'b1; cyc(); dec_ack = 1'b0;
    endtask

    task automatic test_reset_midframe();
        push_bytes('{8'h57, 8'h12});
        cyc(); cyc();
        reset = 1'b0;
        cyc();
        reset = 1'b1;
        n_cmp++; if ({dec_en, wr, frame_err, daddr, wdatadec} !== 51'h0) begin n_bad++; $display("FAIL mid_reset: got %b %b %b %h %h want all 0", dec_en, wr, frame_err, daddr, wdatadec); end
        push_bytes('{8'h52, 8'hAB, 8'hCD});
        exq.push_back('{1'b0, 16'hABCD, 32'h0});
        cyc(); cyc(); cyc();
        r = exq.pop_front();
        n_cmp++; if ({dec_en, wr, daddr, wdatadec} !== {1'b1, r.wr, r.addr, r.data}) begin n_bad++; $display("FAIL mid_rd: got %b %b %h %h want 1 %b %h %h", dec_en, wr, daddr, wdatadec, r.wr, r.addr, r.data); end
        dec_ack = 1'b1; cyc(); dec_ack = 1'b0;
    endtask

    task automatic test_back_to_back();
        push_bytes('{8'h57, 8'h01, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h52, 8'h56, 8'h78});
        exq.push_back('{1'b1, 16'h0102, 32'h11223344});
        exq.push_back('{1'b0, 16'h5678, 32'h0});
        for (int i = 0; i < 7; i++) cyc();
        r = exq.pop_front();
        n_cmp++; if ({dec_en, wr, daddr, wdatadec} !== {1'b1, r.wr, r.addr, r.data}) begin n_bad++; $display("FAIL b2b_first: got %b %b %h %h want 1 %b %h %h", dec_en, wr, daddr, wdatadec, r.wr, r.addr, r.data); end
        dec_ack = 1'b1;
        cyc();
        dec_ack = 1'b0;
        n_cmp++; if (dec_en !== 1'b0 || rx_ren !== 1'b1 || rx_data !== 8'h52) begin n_bad++; $display("FAIL b2b_next_pop: dec_en=%b rx_ren=%b head=%h want 0 1 52", dec_en, rx_ren, rx_data); end
        cyc(); cyc(); cyc();
        r = exq.pop_front();
        n_cmp++; if ({dec_en, wr, daddr, wdatadec} !== {1'b1, r.wr, r.addr, r.data}) begin n_bad++; $display("FAIL b2b_second: got %b %b %h %h want 1 %b %h %h", dec_en, wr, daddr, wdatadec, r.wr, r.addr, r.data); end
        dec_ack = 1'b1; cyc(); dec_ack = 1'b0;
    endtask

    task automatic test_gap();
        push_bytes('{8'h57, 8'h12});
        cyc(); cyc();
`ifdef FRAME_TIMEOUT_EN
        n_ren = 0;
        for (int i = 0; i < 7; i++) begin
            cyc();
            if (frame_err !== 1'b0) n_ren++;
        end
        n_cmp++; if (n_ren !== 0) begin n_bad++; $display("FAIL gap_early: %0d early pulses want 0", n_ren); end
        cyc();
        n_cmp++; if (frame_err !== 1'b1) begin n_bad++; $display("FAIL gap_pulse: got %b want 1", frame_err); end
        push_bytes('{8'h52, 8'h00, 8'h04});
        exq.push_back('{1'b0, 16'h0004, 32'h0});
        cyc();
        n_cmp++; if (frame_err !== 1'b0) begin n_bad++; $display("FAIL gap_err_len: got %b want 0", frame_err); end
        cyc(); cyc();
`else
        n_ren = 0;
        for (int i = 0; i < 100; i++) begin
            cyc();
            if (frame_err !== 1'b0) n_ren++;
        end
        n_cmp++; if (n_ren !== 0) begin n_bad++; $display("FAIL gap_no_pulse: %0d pulses want 0", n_ren); end
        push_bytes('{8'h34, 8'hCA, 8'hFE, 8'hF0, 8'h0D});
        exq.push_back('{1'b1, 16'h1234, 32'hCAFEF00D});
        for (int i = 0; i < 5; i++) cyc();
`endif
        r = exq.pop_front();
        n_cmp++; if ({dec_en, wr, daddr, wdatadec} !== {1'b1, r.wr, r.addr, r.data}) begin n_bad++; $display("FAIL gap_after: got %b %b %h %h want 1 %b %h %h", dec_en, wr, daddr, wdatadec, r.wr, r.addr, r.data); end
        dec_ack = 1'b1; cyc(); dec_ack = 1'b0;
    endtask

    initial begin
        refresh();
        test_reset();
        test_write();
        test_read_wait();
        test_bad_cmd();
        test_reset_midframe();
        test_back_to_back();
        test_gap();
        n_cmp++; if (exq.size() !== 0) begin n_bad++; $display("FAIL sb_leftover: got %0d want 0", exq.size()); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_cmd_decoder.md
Name: uart_cmd_decoder

Overview:
- Upstream neighbour of the APB master in the UART-to-APB bridge.
- Pops bytes from the UART RX FIFO (first-word-fall-through) and assembles framed commands. Frame = command byte, then address bytes MSB-first, then data bytes MSB-first for writes only.
- Presents each decoded request (dec_en, wr, daddr, wdatadec) to the APB master and holds it until the master acknowledges.
- Refuses to issue while the master's read-response FIFO reports wait.

Parameters:
- WIDTH, 32, APB data width; must be a multiple of 8.
- ADDRBITS, 16, APB address width; must be a multiple of 8.
- CMD_WR, 8'h57, command byte for a write frame ('W').
- CMD_RD, 8'h52, command byte for a read frame ('R').
- TIMEOUT_CYCLES, 100000, inter-byte gap limit; used only with FRAME_TIMEOUT_EN.

Ports:
- apb_clk  in  1  bridge clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- rx_data  in  8  head byte of the RX FIFO; valid while rx_empty=0.
- rx_empty  in  1  RX FIFO empty.
- rx_ren  out  1  pop strobe; one byte consumed per cycle it is high.
- wait_fifo  in  1  master response FIFO full; blocks issue.
- dec_ack  in  1  master accepted the current request.
- dec_en  out  1  request valid to the APB master.
- wr  out  1  1 = write, 0 = read.
- daddr  out  ADDRBITS  request address.
- wdatadec  out  WIDTH  write data; 0 for reads.
- frame_err  out  1  one-cycle pulse on a framing error.

Behaviour:
- Reset (reset=0 at a clock edge): state IDLE; dec_en, wr, daddr, wdatadec, frame_err = 0; byte counter cleared. A partial frame is discarded. rx_ren=0 while reset=0.
- rx_ren = !rx_empty && state in {IDLE, ADDR, DATA}. Combinational. Never high in ISSUE.
- IDLE, on a popped byte:
  - CMD_WR: wr<=1 -> ADDR.
  - CMD_RD: wr<=0 -> ADDR.
  - Any other value: byte is consumed, frame_err pulses 1 cycle, state stays IDLE.
- ADDR:
  - Each popped byte shifts in: daddr <= {daddr[ADDRBITS-9:0], rx_data}.
  - After ADDRBITS/8 bytes: write -> DATA; read -> ISSUE with wdatadec=0.
- DATA:
  - Each popped byte shifts into wdatadec the same way.
  - After WIDTH/8 bytes -> ISSUE.
- ISSUE:
  - dec_en is registered: high from the cycle after entry while wait_fifo=0; low whenever wait_fifo=1.
  - wr, daddr and wdatadec are stable throughout ISSUE.
  - dec_ack is sampled only when dec_en=1. On ack: dec_en<=0 and state -> IDLE at the next edge.
  - dec_ack while dec_en=0 is ignored.
- Latency: last frame byte popped in cycle N -> dec_en=1 in cycle N+1 (wait_fifo=0). The cycle after ack, IDLE may pop the next command byte.
- Throughput: 1 byte/cycle. Write frame = 1+ADDRBITS/8+WIDTH/8 bytes (7 at defaults); read frame = 1+ADDRBITS/8 bytes (3).
- rx_empty mid-frame: state holds and waits; no error unless the optional timeout is compiled in.
- Byte counter is sized ceil(log2(WIDTH/8+1)) and cleared on every state change.

Optional Feature:
- Macro: FRAME_TIMEOUT_EN.
- With the macro:
  - Gap counter clears on every pop and on entry to ADDR. It increments each cycle in ADDR/DATA with rx_empty=1.
  - When it reaches TIMEOUT_CYCLES-1: state -> IDLE, partial frame dropped, frame_err pulses 1 cycle.
  - Not active in IDLE or ISSUE.
- Without the macro: no counter; ADDR/DATA wait indefinitely.

Decomposition:
- Shared package uart_bridge_pkg:
  - state enum (IDLE, ADDR, DATA, ISSUE).
  - CMD_WR/CMD_RD defaults.
  - localparams ADDR_BYTES=ADDRBITS/8 and DATA_BYTES=WIDTH/8.
- One sub-module, frame_gap_timer (counter + terminal-count pulse). Instantiated only under FRAME_TIMEOUT_EN.

Test Plan:
- Write frame 57 12 34 DE AD BE EF, FIFO never empty -> rx_ren high 7 consecutive cycles; dec_en=1 the next cycle with wr=1, daddr=16'h1234, wdatadec=32'hDEADBEEF; dec_ack 3 cycles later -> dec_en=0 next cycle, IDLE.
- Read frame 52 00 08 with wait_fifo=1 for 5 cycles -> dec_en stays 0 during the wait, rises the cycle after wait_fifo falls; wr=0, daddr=16'h0008, wdatadec=0.
- Bytes 41 then 52 00 04 -> frame_err single pulse on the 41 pop; following read decodes daddr=16'h0004.
- Reset low for 1 cycle after 57 12 -> all outputs 0; next 52 AB CD decodes as a read of 16'hABCD.
- Back-to-back write then read, with dec_ack asserted the first dec_en cycle -> second command byte popped the cycle after ack; both requests are presented in order with correct fields.
- FRAME_TIMEOUT_EN, TIMEOUT_CYCLES=8: 57 12 then empty -> frame_err pulse after 8 empty cycles, state IDLE; without the macro, no pulse after 100 cycles.
